// File: rtl/fsize_frame_writer_pkg.sv
// Shared types and helpers for the fixed-size frame writer.
// State encodings keep the legacy numeric values so existing debug probes still decode.
package fsize_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_FRSTS   = 3'd2,
        ST_STREAM  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Bits needed to hold 0..max_val inclusive; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fsize_frame_writer_if.sv
// Valid/ready sample stream feeding the frame writer.
interface fsize_frame_writer_if #(
    parameter int unsigned DW = 27
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/fsize_frame_writer_fifo.sv
// Single-clock show-ahead FIFO: head always presents the oldest entry when not empty.
module sync_fifo_fsize #(
    parameter int unsigned DW      = 27,
    parameter int unsigned LEN_LOG = 5
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    head,
    output logic [LEN_LOG:0] level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned      DEPTH    = 2 ** LEN_LOG;
    localparam logic [LEN_LOG:0] FULL_LVL = (LEN_LOG + 1)'(DEPTH);

    logic [DW-1:0]      mem [DEPTH];
    logic [LEN_LOG-1:0] wr_ptr;
    logic [LEN_LOG-1:0] rd_ptr;
    logic [LEN_LOG:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LEN_LOG'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LEN_LOG'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (LEN_LOG + 1)'(1);
                2'b01:   count <= count - (LEN_LOG + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fsize_frame_writer.sv
// Buffers an input sample stream and emits FRST followed by FRAME_LEN contiguous sel=1 words,
// then at least GAP_LEN idle cycles, for the downstream fixed-size delay FIFO.
module fsize_frame_writer
    import fsize_frame_pkg::*;
#(
    parameter int unsigned DW        = 27,
    parameter int unsigned LEN_LOG   = 5,
    parameter int unsigned PREFILL   = 16,
    parameter int unsigned FRAME_LEN = 4300,
    parameter int unsigned GAP_LEN   = 8
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clr_err,
    fsize_frame_writer_if.slave   in_if,
    output logic                  FRST,
    output logic                  sel,
    output logic [DW-1:0]         dot,
    output logic                  busy,
    output logic                  err_underrun,
    output logic [LEN_LOG:0]      level
);

    localparam int unsigned      FCW         = cnt_width(FRAME_LEN);
    localparam int unsigned      GCW         = cnt_width(GAP_LEN);
    localparam logic [LEN_LOG:0] PREFILL_LVL = (LEN_LOG + 1)'(PREFILL);
    localparam logic [FCW-1:0]   FRM_LAST    = FCW'(FRAME_LEN - 1);
    localparam logic [GCW-1:0]   GAP_LAST    = GCW'(GAP_LEN - 1);

    state_t         state;
    state_t         state_nx;
    logic [FCW-1:0] frm_cnt;
    logic [FCW-1:0] frm_cnt_nx;
    logic [GCW-1:0] gap_cnt;
    logic [GCW-1:0] gap_cnt_nx;
    logic           frst_nx;
    logic           sel_nx;
    logic [DW-1:0]  dot_nx;
    logic           err_set;
    logic           err_clr;
    logic           err_nx;

    logic           fifo_push;
    logic           fifo_pop;
    logic [DW-1:0]  fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

    assign in_if.in_ready = ~fifo_full;
    assign fifo_push      = in_if.in_valid & ~fifo_full;
    assign busy           = (state != ST_IDLE);

    sync_fifo_fsize #(
        .DW      (DW),
        .LEN_LOG (LEN_LOG)
    ) u_fifo (
        .CLK   (CLK),
        .RST_X (RST_X),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_if.in_data),
        .head  (fifo_head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx   = state;
        frm_cnt_nx = frm_cnt;
        gap_cnt_nx = gap_cnt;
        frst_nx    = 1'b0;
        sel_nx     = 1'b0;
        dot_nx     = dot;
        fifo_pop   = 1'b0;
        err_set    = 1'b0;
        err_clr    = clr_err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_PREFILL;
                    err_clr  = 1'b1;
                end
            end
            ST_PREFILL: begin
                if (level >= PREFILL_LVL) begin
                    state_nx = ST_FRSTS;
                end else if (abort || !start) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FRSTS: begin
                frst_nx    = 1'b1;
                frm_cnt_nx = '0;
                state_nx   = ST_STREAM;
            end
            ST_STREAM: begin
                // Abort wins over the pop so the pending head stays buffered for the next frame.
                if (abort) begin
                    state_nx   = ST_GAP;
                    gap_cnt_nx = '0;
                end else if (fifo_empty) begin
                    err_set    = 1'b1;
                    state_nx   = ST_GAP;
                    gap_cnt_nx = '0;
                end else begin
                    fifo_pop   = 1'b1;
                    sel_nx     = 1'b1;
                    dot_nx     = fifo_head;
                    frm_cnt_nx = frm_cnt + FCW'(1);
                    if (frm_cnt == FRM_LAST) begin
                        state_nx   = ST_GAP;
                        gap_cnt_nx = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = start ? ST_PREFILL : ST_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + GCW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (err_set) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end else begin
            err_nx = err_underrun;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state        <= ST_IDLE;
            frm_cnt      <= '0;
            gap_cnt      <= '0;
            FRST         <= 1'b0;
            sel          <= 1'b0;
            dot          <= '0;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_nx;
            frm_cnt      <= frm_cnt_nx;
            gap_cnt      <= gap_cnt_nx;
            FRST         <= frst_nx;
            sel          <= sel_nx;
            dot          <= dot_nx;
            err_underrun <= err_nx;
        end
    end

endmodule

// File: tb/tb_fsize_frame_writer.sv
// Directed bench for fsize_frame_writer with a short frame (FRAME_LEN=8, PREFILL=4, GAP_LEN=8).
module tb_fsize_frame_writer;

    localparam int unsigned DW      = 16;
    localparam int unsigned LEN_LOG = 5;

    logic                CLK;
    logic                RST_X;
    logic                start;
    logic                abort;
    logic                clr_err;
    logic                FRST;
    logic                sel;
    logic [DW-1:0]       dot;
    logic                busy;
    logic                err_underrun;
    logic [LEN_LOG:0]    level;

    int unsigned checks;
    int unsigned errors;
    logic [DW-1:0] next_data;

    fsize_frame_writer_if #(.DW(DW)) bus ();

    fsize_frame_writer #(
        .DW        (DW),
        .LEN_LOG   (LEN_LOG),
        .PREFILL   (4),
        .FRAME_LEN (8),
        .GAP_LEN   (8)
    ) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .start        (start),
        .abort        (abort),
        .clr_err      (clr_err),
        .in_if        (bus),
        .FRST         (FRST),
        .sel          (sel),
        .dot          (dot),
        .busy         (busy),
        .err_underrun (err_underrun),
        .level        (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [DW-1:0] v);
        next_data   = v;
        bus.in_data = v;
    endtask

    // One clock; the source advances to the next sample only when a push was accepted.
    task automatic tick();
        logic acc;
        acc = bus.in_valid && bus.in_ready;
        @(posedge CLK);
        #1;
        if (acc) begin
            next_data   = next_data + 1'b1;
            bus.in_data = next_data;
        end
        checks++;
        assert ((FRST & sel) === 1'b0) else begin
            errors++;
            $error("FAIL frst_sel_overlap observed=%0b expected=0", FRST & sel);
        end
    endtask

    task automatic wait_frst(input int max_cyc, output int n);
        n = 0;
        tick();
        n++;
        while (FRST !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("frst_seen", {31'd0, FRST}, 32'd1);
    endtask

    // Counts sel=0 cycles until the next FRST.
    task automatic count_gap(output int zeros);
        int n;
        zeros = 0;
        n = 0;
        tick();
        while (FRST !== 1'b1 && n < 40) begin
            if (sel === 1'b0) zeros++;
            n++;
            tick();
        end
        chk("gap_frst_seen", {31'd0, FRST}, 32'd1);
    endtask

    initial begin
        int n;
        int zeros;
        checks = 0;
        errors = 0;
        RST_X = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        clr_err = 1'b0;
        bus.in_valid = 1'b0;
        set_data('0);
        tick();
        tick();
        RST_X = 1'b1;

        chk("rst_sel",   {31'd0, sel}, 32'd0);
        chk("rst_frst",  {31'd0, FRST}, 32'd0);
        chk("rst_dot",   {16'd0, dot}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, err_underrun}, 32'd0);
        chk("rst_level", {26'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // Continuous input: full frame of 0..7, gap, next frame.
        start = 1'b1;
        bus.in_valid = 1'b1;
        wait_frst(20, n);
        chk("t2_latency", n, 32'd6);
        chk("t2_frst_sel", {31'd0, sel}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_sel", {31'd0, sel}, 32'd1);
            chk("t2_dot", {16'd0, dot}, i);
            if (i == 0) chk("t2_frst_once", {31'd0, FRST}, 32'd0);
        end
        count_gap(zeros);
        chk("t2_gap_len", zeros, 32'd9);
        tick();
        chk("t2_next_sel", {31'd0, sel}, 32'd1);
        chk("t2_next_dot", {16'd0, dot}, 32'd8);
        tick();
        chk("t2_next_dot2", {16'd0, dot}, 32'd9);

        // Reset in the middle of a frame.
        bus.in_valid = 1'b0;
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
        chk("t1_sel",   {31'd0, sel}, 32'd0);
        chk("t1_frst",  {31'd0, FRST}, 32'd0);
        chk("t1_level", {26'd0, level}, 32'd0);
        chk("t1_busy",  {31'd0, busy}, 32'd0);

        // Underrun: only 5 words ever arrive.
        set_data(16'd100);
        start = 1'b1;
        bus.in_valid = 1'b1;
        repeat (5) tick();
        bus.in_valid = 1'b0;
        wait_frst(10, n);
        chk("t3_latency", n, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_sel", {31'd0, sel}, 32'd1);
            chk("t3_dot", {16'd0, dot}, 100 + i);
            chk("t3_level", {26'd0, level}, 4 - i);
        end
        tick();
        chk("t3_sel_fall", {31'd0, sel}, 32'd0);
        chk("t3_err_set", {31'd0, err_underrun}, 32'd1);
        chk("t3_busy_gap", {31'd0, busy}, 32'd1);
        start = 1'b0;
        tick();
        chk("t3_err_sticky", {31'd0, err_underrun}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_err_clr", {31'd0, err_underrun}, 32'd0);
        repeat (5) tick();
        chk("t3_gap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t3_gap_idle", {31'd0, busy}, 32'd0);

        // Abort during the third word; the next frame resumes with the next buffered word.
        set_data(16'd200);
        start = 1'b1;
        bus.in_valid = 1'b1;
        wait_frst(20, n);
        chk("t4_latency", n, 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_dot", {16'd0, dot}, 200 + i);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_sel_off", {31'd0, sel}, 32'd0);
        chk("t4_dot_hold", {16'd0, dot}, 32'd202);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        count_gap(zeros);
        chk("t4_gap_len", zeros, 32'd9);
        tick();
        chk("t4_resume_sel", {31'd0, sel}, 32'd1);
        chk("t4_resume_dot", {16'd0, dot}, 32'd203);

        bus.in_valid = 1'b0;
        start = 1'b0;
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
        chk("t4_rst_level", {26'd0, level}, 32'd0);

        // Fill to full while idle, then drain while refilling.
        set_data(16'd300);
        bus.in_valid = 1'b1;
        repeat (32) tick();
        chk("t5_full_level", {26'd0, level}, 32'd32);
        chk("t5_full_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) tick();
        chk("t5_hold_level", {26'd0, level}, 32'd32);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        wait_frst(10, n);
        chk("t5_latency", n, 32'd3);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_sel", {31'd0, sel}, 32'd1);
            chk("t5_dot", {16'd0, dot}, 300 + i);
            chk("t5_level", {26'd0, level}, 32'd31);
        end
        wait_frst(40, n);
        tick();
        chk("t5_next_dot", {16'd0, dot}, 32'd308);

        // Random control and input activity; overlap is checked every cycle.
        for (int i = 0; i < 400; i++) begin
            start        = ($urandom_range(0, 7) != 0);
            abort        = ($urandom_range(0, 15) == 0);
            clr_err      = ($urandom_range(0, 15) == 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        clr_err = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
